// File: rtl/ef_spi_target.sv
// ef_spi_target - SPI target (slave) core
//
// Receives and transmits one DW-bit frame per SPI transfer, MSB first. sck,
// ssn and mosi are asynchronous to clk, so each passes through a two-flop
// synchronizer. A third flop on sck and ssn provides edge detection. Frames
// keep flowing while ssn stays low: after the DW-th sample the next TX word
// loads straight away.
//
// Optional feature macro: EF_SPI_TARGET_RXFIFO_EN
//   defined     -> RX is a 2**FIFO_AW-entry FIFO
//   not defined -> RX is a single holding register and rx_level reads 0 or 1
//
// Parameters
//   DW        frame width in bits
//   FIFO_AW   RX FIFO address width
// Ports
//   clk, rst_n           system clock and synchronous active-low reset
//   cpol, cpha           SPI mode; must stay static while ssn is low
//   sck, ssn, mosi       asynchronous SPI pins from the controller
//   miso, miso_oe        serial data back to the controller and its enable
//   tx_data/valid/ready  TX holding register write handshake
//   rx_data/valid/ready  received frame read handshake
//   rx_level             number of frames buffered
//   busy                 FSM is in ACTIVE
//   done                 one-cycle pulse per completed frame
//   overrun, underrun    sticky error flags, cleared by clr_flags
module ef_spi_target #(
  parameter int DW      = 8,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpol,
  input  logic               cpha,
  input  logic               sck,
  input  logic               ssn,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  input  logic [DW-1:0]      tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [DW-1:0]      rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [FIFO_AW:0]   rx_level,
  output logic               busy,
  output logic               done,
  output logic               overrun,
  output logic               underrun,
  input  logic               clr_flags
);

  localparam int CW = $clog2(DW) + 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t          state;
  logic [2:0]      sck_q;
  logic [2:0]      ssn_q;
  logic [1:0]      mosi_q;
  logic [CW-1:0]   bit_cnt;
  logic [DW-1:0]   shift_in;
  logic [DW-1:0]   shift_out;
  logic            skip;
  logic [DW-1:0]   tx_hold;
  logic            tx_full;

  logic            sck_rise;
  logic            sck_fall;
  logic            sample_edge;
  logic            shift_edge;
  logic            ssn_fall;
  logic            ssn_high;
  logic            start;
  logic            frame_end;
  logic            load;
  logic            tx_wr;
  logic [DW-1:0]   load_word;
  logic [DW-1:0]   rx_word;
  logic            rx_pop;
  logic            overrun_set;
  logic            underrun_set;

  // Pin synchronizers. The ssn chain resets to 0 so that a reset taken
  // while ssn is held low cannot produce a false falling edge afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q  <= '0;
      ssn_q  <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ssn_q  <= {ssn_q[1:0], ssn};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  // The sample edge is the rising sck edge when cpol == cpha, otherwise the
  // falling edge. mosi_q[1] lines up in time with sck_q[1].
  always_comb begin
    sck_rise    = sck_q[1] & ~sck_q[2];
    sck_fall    = ~sck_q[1] & sck_q[2];
    sample_edge = (cpol == cpha) ? sck_rise : sck_fall;
    shift_edge  = (cpol == cpha) ? sck_fall : sck_rise;
    ssn_fall    = ~ssn_q[1] & ssn_q[2];
    ssn_high    = ssn_q[1];
    start       = (state == IDLE) && ssn_fall;
    frame_end   = (state == ACTIVE) && !ssn_high && sample_edge &&
                  (bit_cnt == CW'(DW - 1));
    load        = start | frame_end;
    load_word   = tx_full ? tx_hold : '0;
    rx_word     = {shift_in[DW-2:0], mosi_q[1]};
    tx_wr       = tx_valid & ~tx_full;
    tx_ready    = ~tx_full;
    underrun_set = start & ~tx_full;
  end

  // TX holding register. A load empties it; a write in the same cycle as a
  // load of an empty register still lands and leaves it full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
    end else if (tx_wr) begin
      tx_hold <= tx_data;
      tx_full <= 1'b1;
    end else if (load) begin
      tx_full <= 1'b0;
    end
  end

  // Transfer FSM. The skip flag keeps the freshly loaded MSB on miso across
  // the first shift edge whenever that edge comes before the first sample
  // (cpha=1, and every continuation frame).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      skip      <= 1'b0;
      busy      <= 1'b0;
      miso_oe   <= 1'b0;
      miso      <= 1'b0;
    end else begin
      miso <= (state == ACTIVE && !ssn_high) ? shift_out[DW-1] : 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (ssn_fall) begin
            state     <= ACTIVE;
            busy      <= 1'b1;
            miso_oe   <= 1'b1;
            shift_out <= load_word;
            skip      <= cpha;
          end
        end
        ACTIVE: begin
          if (ssn_high) begin
            state   <= IDLE;
            busy    <= 1'b0;
            miso_oe <= 1'b0;
            bit_cnt <= '0;
            skip    <= 1'b0;
          end else if (sample_edge) begin
            shift_in <= rx_word;
            if (frame_end) begin
              bit_cnt   <= '0;
              shift_out <= load_word;
              skip      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (shift_edge) begin
            if (skip) begin
              skip <= 1'b0;
            end else begin
              shift_out <= {shift_out[DW-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags and the frame-complete pulse. clr_flags wins over a
  // set arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= frame_end;
      if (clr_flags) begin
        overrun  <= 1'b0;
        underrun <= 1'b0;
      end else begin
        if (overrun_set)  overrun  <= 1'b1;
        if (underrun_set) underrun <= 1'b1;
      end
    end
  end

  assign rx_pop = rx_valid & rx_ready;

`ifdef EF_SPI_TARGET_RXFIFO_EN
  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DW-1:0]      rx_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               rx_full;
  logic               push_ok;

  // A push into a full FIFO still succeeds when a pop frees a slot in the
  // same cycle; otherwise the frame is dropped and flagged.
  always_comb begin
    rx_full     = (count == (FIFO_AW+1)'(DEPTH));
    push_ok     = frame_end && (!rx_full || rx_pop);
    overrun_set = frame_end && rx_full && !rx_pop;
    rx_valid    = (count != '0);
    rx_data     = rx_valid ? rx_mem[rd_ptr] : '0;
    rx_level    = count;
  end

  // Storage array, left unreset; rx_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) rx_mem[wr_ptr] <= rx_word;
  end

  // Pointers wrap modulo the depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (rx_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, rx_pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
`else
  logic [DW-1:0] rx_hold;
  logic          rx_full;
  logic          push_ok;

  // Single-entry RX: the held frame is kept until consumed.
  always_comb begin
    push_ok     = frame_end && (!rx_full || rx_pop);
    overrun_set = frame_end && rx_full && !rx_pop;
    rx_valid    = rx_full;
    rx_data     = rx_hold;
    rx_level    = {{FIFO_AW{1'b0}}, rx_full};
  end

  // Holding register and its full flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_hold <= '0;
      rx_full <= 1'b0;
    end else if (push_ok) begin
      rx_hold <= rx_word;
      rx_full <= 1'b1;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end
`endif

endmodule
